// File: rtl/fp_pkg.sv
// fp_pkg: shared FSM state type and effective-exponent helper for the FP aligner
package fp_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    function automatic logic [31:0] eff_exp(input logic [31:0] e);
        return (e == '0) ? 32'd1 : e;
    endfunction
endpackage

// File: rtl/fp_align_shift_stage.sv
// fp_align_shift_stage: one-bit right shift of {sig,G,R,S} folding R into sticky
module fp_align_shift_stage #(
    parameter int W = 27
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    assign dout = {1'b0, din[W-1:2], din[1] | din[0]};
endmodule

// File: rtl/fp_aligner.sv
// fp_aligner: swaps operands by exponent and aligns the smaller significand one bit per cycle
module fp_aligner
    import fp_pkg::*;
#(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [E-1:0] a_exp,
    input  logic [E-1:0] b_exp,
    input  logic [M-1:0] a_frac,
    input  logic [M-1:0] b_frac,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [E-1:0] exp_out,
    output logic [M:0]   big_sig,
    output logic [M:0]   small_sig,
    output logic         guard,
    output logic         round,
    output logic         sticky,
    output logic         swapped,
    output logic         special
);
    localparam int CW = $clog2(M + 4);
    state_t        state;
    logic [CW-1:0] cnt;
    logic [M+3:0]  ext, ext_nx;
    logic [31:0]   ea, eb, d, nn;
    logic          a_big, spec;
    logic [M:0]    sa, sb;
    always_comb begin
        ea    = eff_exp(32'(a_exp));
        eb    = eff_exp(32'(b_exp));
        a_big = ea >= eb;
        d     = a_big ? ea - eb : eb - ea;
        spec  = (&a_exp) | (&b_exp);
        nn    = spec ? '0 : (d > 32'(M + 3) ? 32'(M + 3) : d);
        sa    = {|a_exp, a_frac};
        sb    = {|b_exp, b_frac};
    end
    fp_align_shift_stage #(.W(M + 4)) u_stage (.din(ext), .dout(ext_nx));
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign small_sig = ext[M+3:3];
    assign guard     = ext[2];
    assign round     = ext[1];
    assign sticky    = ext[0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ext     <= '0;
            exp_out <= '0;
            big_sig <= '0;
            swapped <= 1'b0;
            special <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state   <= SHIFT;
                    cnt     <= CW'(nn);
                    exp_out <= a_big ? a_exp : b_exp;
                    big_sig <= a_big ? sa : sb;
                    ext     <= {a_big ? sb : sa, 3'b000};
                    swapped <= !a_big;
                    special <= spec;
                end
                SHIFT: if (cnt != '0) begin
                    ext <= ext_nx;
                    cnt <= cnt - CW'(1);
                end else begin
                    state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_aligner.sv
// tb_fp_aligner: randomized and directed checks of fp_aligner against a bit-level reference model
module tb_fp_aligner;
    localparam int M = 23;
    localparam int E = 8;
    logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [E-1:0] a_exp = 0, b_exp = 0;
    logic [M-1:0] a_frac = 0, b_frac = 0;
    logic         in_ready, out_valid, guard, round, sticky, swapped, special;
    logic [E-1:0] exp_out;
    logic [M:0]   big_sig, small_sig;
    int           n_chk = 0, n_pass = 0;

    fp_aligner #(.M(M), .E(E)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_exp(a_exp), .b_exp(b_exp), .a_frac(a_frac), .b_frac(b_frac),
        .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out),
        .big_sig(big_sig), .small_sig(small_sig), .guard(guard), .round(round),
        .sticky(sticky), .swapped(swapped), .special(special)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [E-1:0] ae, input logic [M-1:0] af,
                           input logic [E-1:0] be, input logic [M-1:0] bf, input int hold);
        int ea, eb, n, k;
        logic sw, spc, g, r, s;
        logic [M:0] sa, sb, bs, ss, es;
        ea  = (ae == 0) ? 1 : int'(ae);
        eb  = (be == 0) ? 1 : int'(be);
        sw  = ea < eb;
        spc = (ae == '1) || (be == '1);
        sa  = {ae != 0, af};
        sb  = {be != 0, bf};
        bs  = sw ? sb : sa;
        ss  = sw ? sa : sb;
        n   = spc ? 0 : (sw ? eb - ea : ea - eb);
        if (n > M + 3) n = M + 3;
        es = '0; g = 0; r = 0; s = 0;
        for (int i = 0; i <= M; i++) begin
            if (i >= n) es[i-n] = ss[i];
            else if (i == n - 1) g = ss[i];
            else if (i == n - 2) r = ss[i];
            else s |= ss[i];
        end
        check("ready_before", in_ready, 1);
        a_exp = ae; a_frac = af; b_exp = be; b_frac = bf; in_valid = 1;
        tick();
        in_valid = 0;
        k = 0;
        while (!out_valid && k < 40) begin
            a_exp = E'($urandom); b_exp = E'($urandom);
            a_frac = M'($urandom); b_frac = M'($urandom);
            in_valid = 1'($urandom);
            tick();
            k++;
        end
        check("latency", 64'(k), 64'(n + 1));
        for (int h = 0; h <= hold; h++) begin
            check("exp_out", exp_out, ae == be ? ae : (sw ? be : ae));
            check("big_sig", big_sig, bs);
            check("small_sig", small_sig, es);
            check("grs", {guard, round, sticky}, {g, r, s});
            check("swapped", swapped, sw);
            check("special", special, spc);
            check("busy_ready", in_ready, 0);
            check("valid_hold", out_valid, 1);
            if (h < hold) begin
                in_valid = 1'($urandom);
                a_exp = E'($urandom);
                tick();
            end
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        in_valid = 0;
        check("idle_ready", in_ready, 1);
        check("idle_valid", out_valid, 0);
    endtask

    initial begin
        #2;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_outs", {exp_out, big_sig, small_sig, guard, round, sticky, swapped, special}, '0);
        #20 rst_n = 1;
        tick();
        run_txn(8'd130, 23'h0, 8'd128, 23'h0, 0);
        run_txn(8'd100, 23'h0, 8'd105, 23'h7FFFFF, 0);
        run_txn(8'd200, 23'h0, 8'd100, 23'h1, 0);
        run_txn(8'd1, 23'h0, 8'd0, 23'h4, 0);
        run_txn(8'd255, 23'h123456, 8'd10, 23'h0ABCDE, 0);
        run_txn(8'd7, 23'h2AAAAA, 8'd3, 23'h555555, 5);
        run_txn(8'd0, 23'h1, 8'd0, 23'h7FFFFF, 1);
        run_txn(8'd50, 23'h0, 8'd255, 23'h1, 2);
        a_exp = 8'd200; b_exp = 8'd100; a_frac = '0; b_frac = 23'h1; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (5) tick();
        rst_n = 0;
        #1;
        check("abort_ready", in_ready, 1);
        check("abort_valid", out_valid, 0);
        check("abort_outs", {exp_out, big_sig, small_sig, guard, round, sticky, swapped, special}, '0);
        #3 rst_n = 1;
        tick();
        run_txn(8'd130, 23'h0, 8'd128, 23'h0, 0);
        for (int t = 0; t < 60; t++) begin
            logic [E-1:0] ae, be;
            ae = E'($urandom);
            be = E'(int'(ae) + $urandom_range(0, 30) - 15);
            if ($urandom_range(0, 9) == 0) be = E'($urandom);
            if ($urandom_range(0, 15) == 0) ae = 8'hFF;
            if ($urandom_range(0, 15) == 0) be = 8'h00;
            run_txn(ae, M'($urandom), be, M'($urandom), $urandom_range(0, 3));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
